eth_ctrl_port_arbiter: RTL and testbench

ETH_CTRL_PORT_ARBITER -- requirements
Module: eth_ctrl_port_arbiter

---
 rtl/eth_ctrl_port_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_eth_ctrl_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_ctrl_port_arbiter.sv
// -----------------------------------------------------------------------------
// eth_ctrl_port_arbiter
//
// Shares one register-controller port between two requesters. Each cycle, at
// most one requester is granted (round-robin). The grant is driven straight
// onto the controller strobes and fields in the same cycle. One cycle later
// the response (read data or zero for writes) is captured into that
// requester's 2-entry response FIFO.
//
// Ports
//   clk_i, reset_n_i           clock, asynchronous active-low reset
//   req_v_i/req_w_i[r]         request valid / write(1) or read(0)
//   req_addr_i/req_wmask_i/
//   req_data_i[r]              request fields
//   req_ready_and_o[r]         request accepted (combinational grant)
//   resp_v_o/resp_data_o[r]    buffered response to requester r
//   resp_ready_and_i[r]        requester r consumes its response
//   addr_o/write_mask_o/
//   write_data_o               shared controller fields
//   write_en_o/read_en_o       one-cycle controller strobes
//   read_data_i                controller read data, valid the cycle after
//                              read_en_o
//   busy_o                     access in flight or any response buffered
// -----------------------------------------------------------------------------
module eth_ctrl_port_arbiter #(
  parameter  int unsigned data_width_p  = 32,
  parameter  int unsigned addr_width_p  = 32,
  localparam int unsigned mask_width_lp = data_width_p / 8
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic [1:0]                    req_v_i,
  input  logic [1:0]                    req_w_i,
  input  logic [1:0][addr_width_p-1:0]  req_addr_i,
  input  logic [1:0][mask_width_lp-1:0] req_wmask_i,
  input  logic [1:0][data_width_p-1:0]  req_data_i,
  output logic [1:0]                    req_ready_and_o,

  output logic [1:0]                    resp_v_o,
  output logic [1:0][data_width_p-1:0]  resp_data_o,
  input  logic [1:0]                    resp_ready_and_i,

  output logic [addr_width_p-1:0]       addr_o,
  output logic [mask_width_lp-1:0]      write_mask_o,
  output logic [data_width_p-1:0]       write_data_o,
  output logic                          write_en_o,
  output logic                          read_en_o,
  input  logic [data_width_p-1:0]       read_data_i,

  output logic                          busy_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                                last_grant_q,  last_grant_d;
  logic                                inflight_v_q,  inflight_v_d;
  logic                                inflight_id_q, inflight_id_d;
  logic                                inflight_w_q,  inflight_w_d;

  logic [1:0][1:0][data_width_p-1:0]   fifo_mem_q;
  logic [1:0]                          wr_ptr_q, wr_ptr_d;
  logic [1:0]                          rd_ptr_q, rd_ptr_d;
  logic [1:0][1:0]                     occ_q,    occ_d;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [1:0]                          eligible;
  logic [1:0]                          enq;
  logic [1:0]                          deq;
  logic                                grant_v;
  logic                                grant_id;
  logic [data_width_p-1:0]             enq_data;

  // Credit check uses registered occupancy plus the in-flight slot; a dequeue
  // happening this same cycle is deliberately not credited, which keeps the
  // grant path free of the response-ready input.
  always_comb begin
    eligible = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      logic [1:0] pending;
      pending     = occ_q[r] + {1'b0, (inflight_v_q && (inflight_id_q == 1'(r)))};
      eligible[r] = req_v_i[r] && (pending < 2'd2);
    end
  end

  always_comb begin
    grant_id = 1'b0;
    if (eligible == 2'b11) begin
      grant_id = ~last_grant_q;
    end else if (eligible[1]) begin
      grant_id = 1'b1;
    end
    // Gating with reset keeps ready and strobes low while reset is held even
    // though the cleared state would otherwise make a requester eligible.
    grant_v = (|eligible) && reset_n_i;
  end

  assign req_ready_and_o = {grant_v && grant_id, grant_v && !grant_id};
  assign write_en_o      = grant_v &&  req_w_i[grant_id];
  assign read_en_o       = grant_v && !req_w_i[grant_id];

  // With no grant grant_id is 0, so requester 0 fields are forwarded.
  assign addr_o          = req_addr_i[grant_id];
  assign write_mask_o    = req_wmask_i[grant_id];
  assign write_data_o    = req_data_i[grant_id];

  always_comb begin
    last_grant_d  = last_grant_q;
    inflight_v_d  = grant_v;
    inflight_id_d = grant_id;
    inflight_w_d  = req_w_i[grant_id];
    if (grant_v) begin
      last_grant_d = grant_id;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFOs
  // ---------------------------------------------------------------------------
  assign enq_data = inflight_w_q ? '0 : read_data_i;

  always_comb begin
    enq      = '0;
    deq      = '0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    for (int unsigned r = 0; r < 2; r++) begin
      enq[r] = inflight_v_q && (inflight_id_q == 1'(r));
      deq[r] = resp_v_o[r] && resp_ready_and_i[r];
      if (enq[r]) begin
        wr_ptr_d[r] = ~wr_ptr_q[r];
      end
      if (deq[r]) begin
        rd_ptr_d[r] = ~rd_ptr_q[r];
      end
      // Credit check guarantees no enqueue into a full FIFO.
      occ_d[r] = occ_q[r] + {1'b0, enq[r]} - {1'b0, deq[r]};
    end
  end

  always_comb begin
    resp_v_o    = '0;
    resp_data_o = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      resp_v_o[r]    = (occ_q[r] != 2'd0);
      resp_data_o[r] = fifo_mem_q[r][rd_ptr_q[r]];
    end
  end

  assign busy_o = inflight_v_q || (|resp_v_o);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      last_grant_q  <= 1'b1;
      inflight_v_q  <= 1'b0;
      inflight_id_q <= 1'b0;
      inflight_w_q  <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      occ_q         <= '0;
    end else begin
      last_grant_q  <= last_grant_d;
      inflight_v_q  <= inflight_v_d;
      inflight_id_q <= inflight_id_d;
      inflight_w_q  <= inflight_w_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      occ_q         <= occ_d;
    end
  end

  // Storage needs no reset: entries are only observed when occupancy says so.
  always_ff @(posedge clk_i) begin
    for (int unsigned r = 0; r < 2; r++) begin
      if (enq[r]) begin
        fifo_mem_q[r][wr_ptr_q[r]] <= enq_data;
      end
    end
  end

endmodule

// File: tb/tb_eth_ctrl_port_arbiter.sv
module tb_eth_ctrl_port_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 32;
  localparam int unsigned MW = DW / 8;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [1:0]          req_v;
  logic [1:0]          req_w;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][MW-1:0]  req_wmask;
  logic [1:0][DW-1:0]  req_data;
  logic [1:0]          req_ready;
  logic [1:0]          resp_v;
  logic [1:0][DW-1:0]  resp_data;
  logic [1:0]          resp_ready;
  logic [AW-1:0]       addr;
  logic [MW-1:0]       wmask;
  logic [DW-1:0]       wdata;
  logic                write_en;
  logic                read_en;
  logic [DW-1:0]       read_data;
  logic                busy;

  int unsigned total  = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  eth_ctrl_port_arbiter #(
    .data_width_p (DW),
    .addr_width_p (AW)
  ) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .req_v_i          (req_v),
    .req_w_i          (req_w),
    .req_addr_i       (req_addr),
    .req_wmask_i      (req_wmask),
    .req_data_i       (req_data),
    .req_ready_and_o  (req_ready),
    .resp_v_o         (resp_v),
    .resp_data_o      (resp_data),
    .resp_ready_and_i (resp_ready),
    .addr_o           (addr),
    .write_mask_o     (wmask),
    .write_data_o     (wdata),
    .write_en_o       (write_en),
    .read_en_o        (read_en),
    .read_data_i      (read_data),
    .busy_o           (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset ----------------
    reset_n    = 1'b0;
    req_v      = 2'b11;
    req_w      = 2'b00;
    req_addr   = '0;
    req_wmask  = '0;
    req_data   = '0;
    resp_ready = 2'b11;
    read_data  = '0;
    #2;
    chk("rst_ready",  req_ready, 2'b00);
    chk("rst_resp_v", resp_v,    2'b00);
    chk("rst_rd_en",  read_en,   1'b0);
    chk("rst_wr_en",  write_en,  1'b0);
    chk("rst_busy",   busy,      1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    req_v   = 2'b00;
    #1;
    chk("post_rst_idle_ready", req_ready, 2'b00);

    // ---------------- single read on requester 0 ----------------
    tick();
    req_v       = 2'b01;
    req_w       = 2'b00;
    req_addr[0] = 32'h10;
    #1;
    chk("rd_ready",  req_ready, 2'b01);
    chk("rd_en",     read_en,   1'b1);
    chk("rd_wr_en",  write_en,  1'b0);
    chk("rd_addr",   addr,      32'h10);
    chk("rd_busy0",  busy,      1'b0);
    tick();
    req_v     = 2'b00;
    read_data = 32'hDEADBEEF;
    #1;
    chk("rd_en_drop",   read_en, 1'b0);
    chk("rd_resp_v_c1", resp_v,  2'b00);
    chk("rd_busy_c1",   busy,    1'b1);
    tick();
    read_data = 32'h55555555;
    #1;
    chk("rd_resp_v",    resp_v,       2'b01);
    chk("rd_resp_data", resp_data[0], 32'hDEADBEEF);
    tick();
    #1;
    chk("rd_drained_v",    resp_v, 2'b00);
    chk("rd_drained_busy", busy,   1'b0);

    // ---------------- write on requester 1 ----------------
    req_v        = 2'b10;
    req_w        = 2'b10;
    req_addr[1]  = 32'h20;
    req_wmask[1] = 4'hF;
    req_data[1]  = 32'h12345678;
    #1;
    chk("wr_ready", req_ready, 2'b10);
    chk("wr_en",    write_en,  1'b1);
    chk("wr_rd_en", read_en,   1'b0);
    chk("wr_addr",  addr,      32'h20);
    chk("wr_mask",  wmask,     4'hF);
    chk("wr_data",  wdata,     32'h12345678);
    tick();
    req_v     = 2'b00;
    req_w     = 2'b00;
    read_data = 32'hFFFFFFFF;
    #1;
    chk("wr_en_drop", write_en, 1'b0);
    chk("wr_resp_c1", resp_v,   2'b00);
    tick();
    #1;
    chk("wr_resp_v",    resp_v,       2'b10);
    chk("wr_resp_zero", resp_data[1], 32'h0);
    tick();
    #1;
    chk("wr_drained", resp_v, 2'b00);

    // ---------------- contention, responses drained ----------------
    req_v       = 2'b11;
    req_w       = 2'b00;
    req_addr[0] = 32'h100;
    req_addr[1] = 32'h200;
    #1;
    chk("rr_g0_ready", req_ready, 2'b01);
    chk("rr_g0_addr",  addr,      32'h100);
    tick();
    read_data = 32'hA0A0A0A0;
    #1;
    chk("rr_g1_ready", req_ready, 2'b10);
    chk("rr_g1_addr",  addr,      32'h200);
    tick();
    read_data = 32'hA1A1A1A1;
    #1;
    chk("rr_g2_ready", req_ready,    2'b01);
    chk("rr_g2_resp",  resp_v,       2'b01);
    chk("rr_g2_data",  resp_data[0], 32'hA0A0A0A0);
    tick();
    read_data = 32'hA2A2A2A2;
    #1;
    chk("rr_g3_ready", req_ready,    2'b10);
    chk("rr_g3_resp",  resp_v,       2'b10);
    chk("rr_g3_data",  resp_data[1], 32'hA1A1A1A1);
    tick();
    read_data = 32'hA3A3A3A3;
    #1;
    chk("rr_g4_ready", req_ready,    2'b01);
    chk("rr_g4_resp",  resp_v,       2'b01);
    chk("rr_g4_data",  resp_data[0], 32'hA2A2A2A2);
    tick();
    req_v     = 2'b00;
    read_data = 32'hA4A4A4A4;
    #1;
    chk("rr_t1_resp", resp_v,       2'b10);
    chk("rr_t1_data", resp_data[1], 32'hA3A3A3A3);
    tick();
    read_data = '0;
    #1;
    chk("rr_t2_resp", resp_v,       2'b01);
    chk("rr_t2_data", resp_data[0], 32'hA4A4A4A4);
    chk("rr_t2_busy", busy,         1'b1);
    tick();
    #1;
    chk("rr_idle_busy", busy, 1'b0);

    // ---------------- backpressure on requester 0 ----------------
    resp_ready  = 2'b10;
    req_v       = 2'b01;
    req_addr[0] = 32'h30;
    #1;
    chk("bp_a0_ready", req_ready, 2'b01);
    tick();
    req_addr[0] = 32'h34;
    read_data   = 32'hB0B0B0B0;
    #1;
    chk("bp_a1_ready", req_ready, 2'b01);
    chk("bp_a1_addr",  addr,      32'h34);
    tick();
    req_addr[0] = 32'h38;
    read_data   = 32'hB1B1B1B1;
    #1;
    chk("bp_a2_stall", req_ready, 2'b00);
    chk("bp_a2_rd_en", read_en,   1'b0);
    req_v       = 2'b11;
    req_addr[1] = 32'h40;
    #1;
    chk("bp_r1_ready", req_ready, 2'b10);
    chk("bp_r1_addr",  addr,      32'h40);
    tick();
    req_addr[1] = 32'h44;
    read_data   = 32'hC0C0C0C0;
    #1;
    chk("bp_r1b_ready", req_ready,    2'b10);
    chk("bp_full_resp", resp_v,       2'b01);
    chk("bp_full_data", resp_data[0], 32'hB0B0B0B0);
    tick();
    req_v     = 2'b01;
    read_data = 32'hC1C1C1C1;
    #1;
    chk("bp_c21_ready", req_ready,    2'b00);
    chk("bp_c21_resp",  resp_v,       2'b11);
    chk("bp_c21_data1", resp_data[1], 32'hC0C0C0C0);
    tick();
    // FIFO0 full; dequeue and request in the same cycle -> no grant yet
    resp_ready = 2'b11;
    read_data  = '0;
    #1;
    chk("full_deq_ready", req_ready,    2'b00);
    chk("full_deq_data0", resp_data[0], 32'hB0B0B0B0);
    chk("full_deq_data1", resp_data[1], 32'hC1C1C1C1);
    tick();
    #1;
    chk("full_next_ready", req_ready,    2'b01);
    chk("full_next_addr",  addr,         32'h38);
    chk("full_next_rd_en", read_en,      1'b1);
    chk("full_next_data0", resp_data[0], 32'hB1B1B1B1);
    chk("full_next_resp",  resp_v,       2'b01);
    tick();
    req_v     = 2'b00;
    read_data = 32'hB2B2B2B2;
    #1;
    chk("bp_tail_resp", resp_v, 2'b00);
    chk("bp_tail_busy", busy,   1'b1);
    tick();
    read_data = '0;
    #1;
    chk("bp_last_resp", resp_v,       2'b01);
    chk("bp_last_data", resp_data[0], 32'hB2B2B2B2);
    tick();
    #1;
    chk("bp_idle_busy", busy, 1'b0);

    // ---------------- mid-operation reset ----------------
    resp_ready  = 2'b00;
    req_v       = 2'b10;
    req_addr[1] = 32'h50;
    #1;
    chk("mr_g1_ready", req_ready, 2'b10);
    tick();
    read_data   = 32'hD0D0D0D0;
    req_v       = 2'b01;
    req_addr[0] = 32'h60;
    #1;
    chk("mr_g0_ready", req_ready, 2'b01);
    tick();
    req_v     = 2'b00;
    read_data = 32'hD1D1D1D1;
    #1;
    chk("mr_pre_resp", resp_v, 2'b10);
    chk("mr_pre_busy", busy,   1'b1);
    reset_n = 1'b0;
    #1;
    chk("mr_rst_resp", resp_v, 2'b00);
    chk("mr_rst_busy", busy,   1'b0);
    req_v = 2'b11;
    #1;
    chk("mr_rst_ready", req_ready, 2'b00);
    chk("mr_rst_rd_en", read_en,   1'b0);
    tick();
    reset_n    = 1'b1;
    req_v      = 2'b00;
    resp_ready = 2'b11;
    #1;
    chk("mr_rel_rd_en", read_en, 1'b0);
    chk("mr_rel_resp",  resp_v,  2'b00);
    tick();
    #1;
    chk("mr_quiet_resp", resp_v,   2'b00);
    chk("mr_quiet_busy", busy,     1'b0);
    chk("mr_quiet_wr",   write_en, 1'b0);
    req_v = 2'b11;
    #1;
    chk("mr_first_both", req_ready, 2'b01);
    req_v       = 2'b10;
    req_addr[1] = 32'h70;
    #1;
    chk("mr_req1_ready", req_ready, 2'b10);
    chk("mr_req1_rd_en", read_en,   1'b1);
    chk("mr_req1_addr",  addr,      32'h70);
    tick();
    req_v = 2'b00;
    #1;
    chk("mr_req1_busy", busy, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
